// File: rtl/rfid_cmd_decoder.sv
// Reader-command decoder: captures a packet on the falling edge of packet_rdy, splits it by
// opcode class and queues it in a FIFO. Optional statistics are enabled by RFID_DEC_STATS_EN.
module rfid_cmd_decoder #(
  parameter int unsigned PKT_W      = 128,
  parameter int unsigned CMD_W      = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [PKT_W-1:0]              input_in,
  input  logic [1:0]                    op_code,
  input  logic                          packet_rdy,
  input  logic                          out_ready,
  input  logic                          clear_stats,
  output logic                          out_valid,
  output logic [CMD_W-1:0]              command,
  output logic [3:0]                    cmd_len,
  output logic [PKT_W-3:0]              data_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [7:0]                    drop_cnt,
  output logic [7:0]                    err_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned DW = PKT_W - 2;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  localparam logic [0:0] ST_WAIT_LOW  = 1'b0;
  localparam logic [0:0] ST_WAIT_HIGH = 1'b1;

  logic [0:0]       r_state;
  logic             w_capture;
  logic             w_legal;
  logic [CMD_W-1:0] w_cmd;
  logic [3:0]       w_len;
  logic [DW-1:0]    w_data;

  logic [CMD_W-1:0] r_mem_cmd  [FIFO_DEPTH];
  logic [3:0]       r_mem_len  [FIFO_DEPTH];
  logic [DW-1:0]    r_mem_data [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_reject;
  logic [AW-1:0]    w_rd_next;
  logic [AW:0]      w_count_next;
  logic [CMD_W-1:0] w_head_cmd;
  logic [3:0]       w_head_len;
  logic [DW-1:0]    w_head_data;

  assign w_capture = (r_state == ST_WAIT_HIGH) && !packet_rdy;

  always_comb begin
    w_legal = 1'b1;
    w_cmd   = '0;
    w_len   = 4'd0;
    w_data  = '0;
    case (op_code)
      2'd0: begin
        w_cmd  = CMD_W'(input_in[PKT_W-1 -: 2]);
        w_len  = 4'd2;
        w_data = input_in[PKT_W-3:0];
      end
      2'd1: begin
        w_cmd  = CMD_W'(input_in[PKT_W-1 -: 4]);
        w_len  = 4'd4;
        w_data = DW'(input_in[PKT_W-5:0]);
      end
      2'd2: begin
        w_cmd  = CMD_W'(input_in[PKT_W-1 -: 8]);
        w_len  = 4'd8;
        w_data = DW'(input_in[PKT_W-9:0]);
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_full    = (r_count == FULL_CNT);
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid && out_ready;
  // A full queue still accepts when the head leaves in the same cycle.
  assign w_push    = w_capture && w_legal && (!w_full || w_pop);
  assign w_drop    = w_capture && w_legal && w_full && !w_pop;
  assign w_reject  = w_capture && !w_legal;
  assign w_rd_next = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // The new head may be the entry being written this very cycle.
  always_comb begin
    w_head_cmd  = r_mem_cmd[w_rd_next];
    w_head_len  = r_mem_len[w_rd_next];
    w_head_data = r_mem_data[w_rd_next];
    if (w_push && (r_wr_ptr == w_rd_next)) begin
      w_head_cmd  = w_cmd;
      w_head_len  = w_len;
      w_head_data = w_data;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_cmd[r_wr_ptr]  <= w_cmd;
      r_mem_len[r_wr_ptr]  <= w_len;
      r_mem_data[r_wr_ptr] <= w_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_WAIT_LOW;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      command  <= '0;
      cmd_len  <= 4'd0;
      data_out <= '0;
    end else begin
      r_state  <= packet_rdy ? ST_WAIT_HIGH : ST_WAIT_LOW;
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_count_next != '0) begin
        command  <= w_head_cmd;
        cmd_len  <= w_head_len;
        data_out <= w_head_data;
      end
    end
  end

  assign fifo_count = r_count;

`ifdef RFID_DEC_STATS_EN
  logic       r_overflow;
  logic [7:0] r_drop_cnt;
  logic [7:0] r_err_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= 8'd0;
      r_err_cnt  <= 8'd0;
    end else if (clear_stats) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= 8'd0;
      r_err_cnt  <= 8'd0;
    end else begin
      if (w_drop) r_overflow <= 1'b1;
      if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
      if (w_reject && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;
  assign err_cnt  = r_err_cnt;
`else
  logic [2:0] w_unused_stats;
  assign w_unused_stats = {clear_stats, w_drop, w_reject};
  assign overflow = 1'b0;
  assign drop_cnt = 8'd0;
  assign err_cnt  = 8'd0;
`endif

endmodule

// File: tb/tb_rfid_cmd_decoder.sv
// Directed self-checking bench for rfid_cmd_decoder with the default parameters.
module tb_rfid_cmd_decoder;

`ifdef RFID_DEC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset_n;
  logic [127:0] input_in;
  logic [1:0]   op_code;
  logic         packet_rdy;
  logic         out_ready;
  logic         clear_stats;
  logic         out_valid;
  logic [7:0]   command;
  logic [3:0]   cmd_len;
  logic [125:0] data_out;
  logic [2:0]   fifo_count;
  logic         overflow;
  logic [7:0]   drop_cnt;
  logic [7:0]   err_cnt;

  int total = 0;
  int bad   = 0;

  rfid_cmd_decoder #(.PKT_W(128), .CMD_W(8), .FIFO_DEPTH(4)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .input_in    (input_in),
    .op_code     (op_code),
    .packet_rdy  (packet_rdy),
    .out_ready   (out_ready),
    .clear_stats (clear_stats),
    .out_valid   (out_valid),
    .command     (command),
    .cmd_len     (cmd_len),
    .data_out    (data_out),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .drop_cnt    (drop_cnt),
    .err_cnt     (err_cnt)
  );

  always #5 clock = ~clock;

  // Packet high for hi cycles, then low for the capture edge; optionally pops in that cycle.
  task automatic send_pkt(input logic [127:0] pkt, input logic [1:0] op, input int hi,
                          input logic pop_cap);
    input_in   = pkt;
    op_code    = op;
    packet_rdy = 1'b1;
    repeat (hi) begin @(posedge clock); #1; end
    packet_rdy = 1'b0;
    out_ready  = pop_cap;
    @(posedge clock); #1;
    out_ready  = 1'b0;
    input_in   = '1;
    op_code    = 2'd2;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; input_in = '0; op_code = 2'd0; packet_rdy = 1'b0;
    out_ready = 1'b0; clear_stats = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    total++; if (command !== 8'h00) begin bad++; $display("FAIL rst_cmd got=%h exp=00", command); end
    total++; if (cmd_len !== 4'd0) begin bad++; $display("FAIL rst_len got=%0d exp=0", cmd_len); end
    total++; if (data_out !== '0) begin bad++; $display("FAIL rst_data got=%h exp=0", data_out); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", fifo_count); end
    total++; if ({overflow, drop_cnt, err_cnt} !== 17'd0) begin
      bad++; $display("FAIL rst_stats got=%b/%0d/%0d exp=0/0/0", overflow, drop_cnt, err_cnt);
    end
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_class2();
    input_in = {8'hC1, 120'h1234}; op_code = 2'd2; packet_rdy = 1'b1;
    repeat (3) begin @(posedge clock); #1; end
    packet_rdy = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL c2_early got=%b exp=0", out_valid); end
    @(posedge clock); #1;
    input_in = '1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL c2_valid got=%b exp=1", out_valid); end
    total++; if (command !== 8'hC1) begin bad++; $display("FAIL c2_cmd got=%h exp=c1", command); end
    total++; if (cmd_len !== 4'd8) begin bad++; $display("FAIL c2_len got=%0d exp=8", cmd_len); end
    total++; if (data_out !== 126'h1234) begin
      bad++; $display("FAIL c2_data got=%h exp=1234", data_out);
    end
    total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL c2_count got=%0d exp=1", fifo_count); end
    pop_one();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL c2_popped got=%b exp=0", out_valid); end
    total++; if (command !== 8'hC1) begin bad++; $display("FAIL c2_hold got=%h exp=c1", command); end
  endtask

  task automatic test_class01();
    logic [125:0] exp0;
    exp0 = {1'b1, 125'h5A};
    send_pkt({2'b01, 1'b1, 125'h5A}, 2'd0, 1, 1'b0);
    send_pkt({4'b1001, 124'hABC}, 2'd1, 2, 1'b0);
    total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL c01_count got=%0d exp=2", fifo_count); end
    total++; if (command !== 8'h01) begin bad++; $display("FAIL c0_cmd got=%h exp=01", command); end
    total++; if (cmd_len !== 4'd2) begin bad++; $display("FAIL c0_len got=%0d exp=2", cmd_len); end
    total++; if (data_out !== exp0) begin
      bad++; $display("FAIL c0_data got=%h exp=%h", data_out, exp0);
    end
    pop_one();
    total++; if (command !== 8'h09) begin bad++; $display("FAIL c1_cmd got=%h exp=09", command); end
    total++; if (cmd_len !== 4'd4) begin bad++; $display("FAIL c1_len got=%0d exp=4", cmd_len); end
    total++; if (data_out !== 126'hABC) begin
      bad++; $display("FAIL c1_data got=%h exp=abc", data_out);
    end
    pop_one();
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL c01_empty got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_overflow();
    logic [7:0] ec;
    for (int i = 0; i < 6; i++) send_pkt({8'h10 + 8'(i), 120'(i)}, 2'd2, 1, 1'b0);
    total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", fifo_count); end
    total++; if (drop_cnt !== (STATS ? 8'd2 : 8'd0)) begin
      bad++; $display("FAIL ovf_drop got=%0d exp=%0d", drop_cnt, STATS ? 2 : 0);
    end
    total++; if (overflow !== STATS) begin
      bad++; $display("FAIL ovf_flag got=%b exp=%b", overflow, STATS);
    end
    for (int i = 0; i < 4; i++) begin
      ec = 8'h10 + 8'(i);
      total++; if (command !== ec || data_out !== 126'(i)) begin
        bad++; $display("FAIL ovf_drain%0d got=%h/%h exp=%h/%h", i, command, data_out, ec, i);
      end
      pop_one();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_full_pop();
    logic [7:0] ec;
    for (int i = 0; i < 4; i++) send_pkt({8'h20 + 8'(i), 120'(i)}, 2'd2, 1, 1'b0);
    send_pkt({8'h24, 120'h4}, 2'd2, 1, 1'b1);
    total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL fp_count got=%0d exp=4", fifo_count); end
    total++; if (drop_cnt !== (STATS ? 8'd2 : 8'd0)) begin
      bad++; $display("FAIL fp_drop got=%0d exp=%0d", drop_cnt, STATS ? 2 : 0);
    end
    for (int i = 1; i < 5; i++) begin
      ec = 8'h20 + 8'(i);
      total++; if (command !== ec) begin bad++; $display("FAIL fp_drain%0d got=%h exp=%h", i, command, ec); end
      pop_one();
    end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL fp_empty got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_illegal();
    send_pkt({8'h77, 120'h1}, 2'd3, 1, 1'b0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ill_valid got=%b exp=0", out_valid); end
    total++; if (err_cnt !== (STATS ? 8'd1 : 8'd0)) begin
      bad++; $display("FAIL ill_err got=%0d exp=%0d", err_cnt, STATS ? 1 : 0);
    end
    clear_stats = 1'b1;
    @(posedge clock); #1;
    clear_stats = 1'b0;
    total++; if ({overflow, drop_cnt, err_cnt} !== 17'd0) begin
      bad++; $display("FAIL clr_stats got=%b/%0d/%0d exp=0/0/0", overflow, drop_cnt, err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) send_pkt({8'h30 + 8'(i), 120'h9}, 2'd2, 1, 1'b0);
    total++; if (fifo_count !== 3'd3) begin bad++; $display("FAIL rm_pre got=%0d exp=3", fifo_count); end
    #2 reset_n = 1'b0;
    #1;
    total++; if ({out_valid, command, cmd_len, fifo_count} !== 16'd0 || data_out !== '0) begin
      bad++; $display("FAIL rm_async got=%b/%h/%0d/%0d exp=0", out_valid, command, cmd_len, fifo_count);
    end
    packet_rdy = 1'b1;
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    input_in = {8'h5E, 120'h77}; op_code = 2'd2; packet_rdy = 1'b0;
    @(posedge clock); #1;
    total++; if (fifo_count !== 3'd1 || command !== 8'h5E) begin
      bad++; $display("FAIL rm_capture got=%0d/%h exp=1/5e", fifo_count, command);
    end
  endtask

  initial begin
    test_reset();
    test_class2();
    test_class01();
    test_overflow();
    test_full_pop();
    test_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rfid_cmd_decoder.md
# rfid_cmd_decoder

Parametrised reader-command decoder with a packet queue. Captures a full demodulated packet when `packet_rdy` falls and splits it into a right-justified command field and a payload field, using the 2-bit opcode class. Decoded packets are queued in a small FIFO and handed downstream over a valid/ready handshake. It sits between the PIE demodulator/packet assembler and the tag command state machine. Unlike a single-register decoder, it buffers back-to-back packets, rejects illegal classes and reports drops.

## Interface
Parameters:
- `PKT_W`, 128: packet width in bits; ≥16.
- `CMD_W`, 8: width of the `command` output; ≥8.
- `FIFO_DEPTH`, 4: decoded-packet queue depth; power of two, ≥2.

Ports:
- `clock`  in  1  single clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `input_in`  in  PKT_W  packet, MSB = first received bit.
- `op_code`  in  2  class: 0 = 2-bit command, 1 = 4-bit, 2 = 8-bit, 3 = illegal.
- `packet_rdy`  in  1  level from assembler; packet is valid on its falling edge.
- `out_ready`  in  1  downstream accepts the head entry.
- `clear_stats`  in  1  synchronous clear of the counters and the sticky flag.
- `out_valid`  out  1  FIFO non-empty.
- `command`  out  CMD_W  head command, right-justified, zero-extended.
- `cmd_len`  out  4  head command length: 2, 4 or 8.
- `data_out`  out  PKT_W-2  head payload, right-justified, zero-extended.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  occupancy.
- `overflow`  out  1  sticky; set on any dropped packet.
- `drop_cnt`  out  8  saturating count of packets dropped on a full FIFO.
- `err_cnt`  out  8  saturating count of packets rejected for `op_code` = 3.

## Operation
- Edge detector FSM, WAIT_LOW / WAIT_HIGH. Reset state is WAIT_LOW.
  - WAIT_LOW → WAIT_HIGH when `packet_rdy` = 1.
  - WAIT_HIGH stays while `packet_rdy` = 1.
  - WAIT_HIGH with `packet_rdy` = 0 produces a capture event and returns to WAIT_LOW.
- On a capture event, `input_in` and `op_code` are sampled in that same cycle and decoded combinationally:
  - class 0: cmd = `input_in[PKT_W-1:PKT_W-2]`, payload = `input_in[PKT_W-3:0]`, len 2.
  - class 1: cmd = top 4 bits, payload = the remaining PKT_W-4 bits, len 4.
  - class 2: cmd = top 8 bits, payload = the remaining PKT_W-8 bits, len 8.
  - class 3: nothing is pushed; `err_cnt` increments.
- Push rules:
  - A decoded entry is pushed when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Otherwise the packet is dropped: `drop_cnt` increments and `overflow` sets.
- Pop occurs when `out_valid` && `out_ready`.
- The outputs always show the head entry. When the FIFO is empty they hold their last value; at reset they are 0.
- Counters saturate at 255.
- `clear_stats` zeroes `drop_cnt`, `err_cnt` and `overflow`. If `clear_stats` coincides with an increment, the clear wins.
- FIFO pointers wrap modulo FIFO_DEPTH; the extra bit in `fifo_count` distinguishes full from empty.

## Timing
- Reset values: FSM = WAIT_LOW; FIFO empty; `out_valid`, `command`, `cmd_len`, `data_out`, `fifo_count`, `overflow`, `drop_cnt`, `err_cnt` all 0.
- Latency: `packet_rdy` is sampled low at edge N with the FSM in WAIT_HIGH. The entry is written at edge N, and `out_valid`/head data are visible after edge N (1 cycle after the falling level is sampled).
- Minimum spacing: a 1-cycle-high `packet_rdy` pulse yields one capture. Back-to-back packets need at least 1 high and 1 low cycle each.
- Pop at edge M: the next entry appears after edge M; with no next entry, `out_valid` = 0 after edge M.
- Simultaneous push and pop: `fifo_count` is unchanged. If the FIFO is empty, the pop does not occur (`out_valid` was 0).
- Reset asserted mid-operation: the queue is flushed immediately and any pending capture is lost. If `packet_rdy` is high when reset releases, the FSM first moves to WAIT_HIGH, so a falling edge is still captured.
- Changes on `input_in` outside the capture cycle have no effect.

## Configuration
- `RFID_DEC_STATS_EN` defined: `drop_cnt`, `err_cnt`, `overflow` and the `clear_stats` logic are implemented as described.
- `RFID_DEC_STATS_EN` undefined: the counters and the flag are tied to 0 and `clear_stats` is ignored. Drop and reject behaviour is unchanged.

## Test plan
- Class 2: PKT_W = 128, `input_in[127:120]` = 8'hC1, low bits = 120'h1234, `op_code` = 2, `packet_rdy` high 3 cycles then low → one entry: `command` = 8'hC1, `cmd_len` = 8, `data_out` = 126'h1234; `out_valid` rises the cycle after the low sample.
- Class 0 and class 1: top bits 2'b01 with `op_code` 0 → `command` = 8'h01, `cmd_len` = 2. Top nibble 4'b1001 with `op_code` 1 → `command` = 8'h09, `cmd_len` = 4. Both entries queue in order; `fifo_count` = 2.
- Overflow: `out_ready` = 0, 6 packets sent with FIFO_DEPTH = 4 → `fifo_count` = 4, `drop_cnt` = 2, `overflow` = 1. Draining returns the first 4 packets in order.
- Full plus simultaneous pop: FIFO full, `out_ready` = 1 in the capture cycle → no drop; `fifo_count` stays 4; the new packet becomes the tail.
- Illegal class: `op_code` = 3 → no push, `err_cnt` = 1. Then `clear_stats` = 1 for one cycle → `err_cnt` = 0, `overflow` = 0.
- Reset mid-run: 3 entries queued, `reset_n` pulsed low → all outputs 0 immediately (asynchronous). Without `RFID_DEC_STATS_EN`, rerunning the overflow case gives `drop_cnt` = 0 with 2 packets still lost.
